data_mem_unit: RTL and testbench
================================

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 The block SHALL have parameter mbus, default 32, giving the data/address bus width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 256, giving the number of mbus-bit words of storage.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port MWE  input  1  write request from the processor.
REQ-006 Port MRE  input  1  read request from the processor.
REQ-007 Port addressData  input  mbus  byte address of the access.
REQ-008 Port storeData  input  mbus  write data.
REQ-009 Port loadedData  output  mbus  last successfully read word; feeds the processor load path.
REQ-010 Port ready  output  1  high when a new request can be accepted.
REQ-011 Port done  output  1  one-cycle pulse marking completion of an accepted request.
REQ-012 Port error  output  1  one-cycle pulse, coincident with done, marking a rejected request.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS and RESP; ready=1 only in IDLE.
REQ-014 A request SHALL be accepted at a rising edge where state=IDLE and (MRE|MWE)=1; addressData, storeData, MWE and MRE are latched at that edge.
REQ-015 Requests presented while ready=0 SHALL be ignored: no latch, no state change, no memory effect.
REQ-016 Word index SHALL be addressData[2+log2(DEPTH)-1:2]; byte address range 0 .. 4*DEPTH-4.
REQ-017 A request SHALL be illegal if MWE=MRE=1, addressData[1:0]!=0, or addressData >= 4*DEPTH.
REQ-018 A legal request SHALL move IDLE->ACCESS at the accept edge (E0), and ACCESS->RESP at edge E1.
REQ-019 A legal read SHALL, at E1, load loadedData with mem[index]; done=1 during the RESP cycle.
REQ-020 A legal write SHALL, at E1, store the latched storeData into mem[index]; loadedData unchanged; done=1 during RESP.
REQ-021 An illegal request SHALL move IDLE->RESP at E0 with done=1, error=1 in RESP; memory and loadedData unchanged.
REQ-022 RESP SHALL always return to IDLE at the next edge; done and error deassert there.
REQ-023 Latency: legal access = 2 edges from accept to done; illegal = 1 edge; back-to-back throughput = one request per 3 cycles (legal).
REQ-024 A read of a word written earlier SHALL return the written value; read-after-write to the same index in consecutive requests returns new data.
REQ-025 loadedData SHALL hold its value between reads, across writes and across illegal requests.
REQ-026 done, error and ready SHALL be registered outputs derived from state only (no combinational input-to-output path).

Reset
REQ-027 On a rising edge with rst=1: state=IDLE, loadedData=0, done=0, error=0, ready=1 after the edge.
REQ-028 Reset SHALL take priority over all activity; rst=1 at edge E1 of a pending write SHALL suppress the write.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 A request presented during the reset edge SHALL NOT be accepted.

Structure
REQ-031 The FSM state enum and the default mbus/DEPTH constants SHALL be placed in the shared ProcessorStructs package.
REQ-032 Storage SHALL be one sub-module, data_ram (single-port synchronous, one read or write per cycle, registered read); data_mem_unit holds the FSM, latches and legality check.

Verification
REQ-033 Reset: rst=1 for 2 cycles with MRE=1 -> ready=1, done=0, error=0, loadedData=0, no access accepted.
REQ-034 Write/read: MWE, addr=0x10, data=0x0000003F; then MRE, addr=0x10 -> done 2 edges after each accept, loadedData=0x0000003F, error=0.
REQ-035 Illegal: MWE=MRE=1 at addr=0x8; then MRE at addr=0x6; then MRE at addr=0x400 (DEPTH=256) -> each: done=error=1 one edge after accept, loadedData unchanged.
REQ-036 Busy ignore: MRE at addr=0x10 then MWE at addr=0x10, data=0xFFFFFFFF held during ACCESS/RESP -> only the read completes; later read of 0x10 returns 0x0000003F.
REQ-037 Reset mid-write: MWE addr=0x20 data=0x12345678, rst=1 at E1 -> no done; later read of 0x20 returns prior contents (not 0x12345678).
REQ-038 Boundary: MWE at last word addr=0x3FC, data=0xA5A5A5A5, then read 0x3FC and 0x0 -> 0xA5A5A5A5 at 0x3FC, 0x0 unaffected.

Source files
------------

// File: rtl/data_mem_unit_pkg.sv
// Shared processor types: data memory FSM states and default bus/storage sizes.
package ProcessorStructs;

    localparam int MBUS_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } memState_e;

endpackage

// File: rtl/data_mem_unit_ram.sv
// Single-port synchronous word RAM with a registered read port that holds between reads.
module data_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// Data memory front end: request acceptance, legality check and IDLE/ACCESS/RESP handshake around data_ram.
module data_mem_unit
    import ProcessorStructs::*;
#(
    parameter int mbus  = MBUS_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MWE,
    input  logic            MRE,
    input  logic [mbus-1:0] addressData,
    input  logic [mbus-1:0] storeData,
    output logic [mbus-1:0] loadedData,
    output logic            ready,
    output logic            done,
    output logic            error
);

    localparam int AW = $clog2(DEPTH);

    memState_e       state_q, state_d;
    logic [mbus-1:0] addr_q, addr_d;
    logic [mbus-1:0] wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            re_q, re_d;
    logic            done_q, error_q, ready_q;

    logic            reqValid;
    logic            reqLegal;
    logic            ramWe;
    logic            ramRe;

    // Out of range means any address bit above the word index is set.
    assign reqValid = MWE | MRE;
    assign reqLegal = !(MWE && MRE)
                   && (addressData[1:0] == 2'b00)
                   && (addressData[mbus-1:AW+2] == '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        re_d    = re_q;
        unique case (state_q)
            IDLE: begin
                if (reqValid) begin
                    addr_d  = addressData;
                    wdata_d = storeData;
                    we_d    = MWE;
                    re_d    = MRE;
                    state_d = reqLegal ? ACCESS : RESP;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            done_q  <= (state_d == RESP);
            error_q <= (state_q == IDLE) && reqValid && !reqLegal;
            ready_q <= (state_d == IDLE);
        end
    end

    // Reset at the access edge must suppress the write, so rst gates the strobe.
    assign ramWe = (state_q == ACCESS) && we_q && !rst;
    assign ramRe = (state_q == ACCESS) && re_q && !rst;

    data_ram #(
        .WIDTH (mbus),
        .DEPTH (DEPTH)
    ) u_data_ram (
        .clk     (clk),
        .rst_i   (rst),
        .we_i    (ramWe),
        .re_i    (ramRe),
        .addr_i  (addr_q[AW+1:2]),
        .wdata_i (wdata_q),
        .rdata_o (loadedData)
    );

    assign done  = done_q;
    assign error = error_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: vector table of transactions plus reset corner sequences.
module tb_data_mem_unit;

    logic        clk;
    logic        rst;
    logic        MWE;
    logic        MRE;
    logic [31:0] addressData;
    logic [31:0] storeData;
    logic [31:0] loadedData;
    logic        ready;
    logic        done;
    logic        error;

    int checkCount;
    int failCount;

    typedef struct {
        string       tag;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] data;
        int          expLat;
        logic        expErr;
        logic [31:0] expLoaded;
        logic        holdBusy;
    } vector_t;

    vector_t vectors [12];

    data_mem_unit #(
        .mbus  (32),
        .DEPTH (256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MWE         (MWE),
        .MRE         (MRE),
        .addressData (addressData),
        .storeData   (storeData),
        .loadedData  (loadedData),
        .ready       (ready),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One request from IDLE through RESP and back; optionally holds a write request during the busy window.
    task automatic applyStimulus(input vector_t v);
        int lat;
        @(negedge clk);
        checkOutput({v.tag, " ready before"}, {31'd0, ready}, 32'd1);
        MWE         = v.we;
        MRE         = v.re;
        addressData = v.addr;
        storeData   = v.data;
        @(posedge clk);
        #1;
        if (v.holdBusy) begin
            MWE         = 1'b1;
            MRE         = 1'b0;
            addressData = 32'h10;
            storeData   = 32'hFFFF_FFFF;
        end else begin
            MWE = 1'b0;
            MRE = 1'b0;
        end
        lat = 1;
        while (done !== 1'b1 && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({v.tag, " latency"}, lat, v.expLat);
        checkOutput({v.tag, " error"}, {31'd0, error}, {31'd0, v.expErr});
        checkOutput({v.tag, " ready in RESP"}, {31'd0, ready}, 32'd0);
        checkOutput({v.tag, " loadedData"}, loadedData, v.expLoaded);
        @(posedge clk);
        #1;
        MWE = 1'b0;
        MRE = 1'b0;
        checkOutput({v.tag, " done drop"}, {31'd0, done}, 32'd0);
        checkOutput({v.tag, " error drop"}, {31'd0, error}, 32'd0);
        checkOutput({v.tag, " ready back"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic runRead(input string tag, input logic [31:0] addr, input logic [31:0] expLoaded);
        vector_t v;
        v = '{tag, 1'b0, 1'b1, addr, 32'h0, 2, 1'b0, expLoaded, 1'b0};
        applyStimulus(v);
    endtask

    initial begin
        checkCount  = 0;
        failCount   = 0;
        rst         = 1'b1;
        MWE         = 1'b0;
        MRE         = 1'b1;
        addressData = 32'h10;
        storeData   = 32'h0;

        //             tag            we    re    addr         data          lat err  loaded        hold
        vectors[0]  = '{"wr 0x10",    1'b1, 1'b0, 32'h10,      32'h0000_003F, 2, 1'b0, 32'h0,        1'b0};
        vectors[1]  = '{"rd 0x10",    1'b0, 1'b1, 32'h10,      32'h0,         2, 1'b0, 32'h0000_003F, 1'b0};
        vectors[2]  = '{"ill both",   1'b1, 1'b1, 32'h8,       32'h0,         1, 1'b1, 32'h0000_003F, 1'b0};
        vectors[3]  = '{"ill align",  1'b0, 1'b1, 32'h6,       32'h0,         1, 1'b1, 32'h0000_003F, 1'b0};
        vectors[4]  = '{"ill range",  1'b0, 1'b1, 32'h400,     32'h0,         1, 1'b1, 32'h0000_003F, 1'b0};
        vectors[5]  = '{"rd busy",    1'b0, 1'b1, 32'h10,      32'h0,         2, 1'b0, 32'h0000_003F, 1'b1};
        vectors[6]  = '{"rd after",   1'b0, 1'b1, 32'h10,      32'h0,         2, 1'b0, 32'h0000_003F, 1'b0};
        vectors[7]  = '{"wr 0x20",    1'b1, 1'b0, 32'h20,      32'hCAFE_F00D, 2, 1'b0, 32'h0000_003F, 1'b0};
        vectors[8]  = '{"wr 0x0",     1'b1, 1'b0, 32'h0,       32'h1111_2222, 2, 1'b0, 32'h0000_003F, 1'b0};
        vectors[9]  = '{"wr 0x3FC",   1'b1, 1'b0, 32'h3FC,     32'hA5A5_A5A5, 2, 1'b0, 32'h0000_003F, 1'b0};
        vectors[10] = '{"rd 0x3FC",   1'b0, 1'b1, 32'h3FC,     32'h0,         2, 1'b0, 32'hA5A5_A5A5, 1'b0};
        vectors[11] = '{"rd 0x0",     1'b0, 1'b1, 32'h0,       32'h0,         2, 1'b0, 32'h1111_2222, 1'b0};

        // Reset held for two edges while a read is being requested.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset ready", {31'd0, ready}, 32'd1);
            checkOutput("reset done", {31'd0, done}, 32'd0);
            checkOutput("reset error", {31'd0, error}, 32'd0);
            checkOutput("reset loadedData", loadedData, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        MRE = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post-reset idle ready", {31'd0, ready}, 32'd1);
        checkOutput("post-reset idle done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vectors[i]);
        end

        // Reset asserted at the access edge of a write must cancel it.
        @(negedge clk);
        MWE         = 1'b1;
        addressData = 32'h20;
        storeData   = 32'h1234_5678;
        @(posedge clk);
        #1;
        MWE = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset done", {31'd0, done}, 32'd0);
        checkOutput("midreset ready", {31'd0, ready}, 32'd1);
        checkOutput("midreset loadedData", loadedData, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("midreset no done", {31'd0, done}, 32'd0);
        end
        runRead("rd 0x20 kept", 32'h20, 32'hCAFE_F00D);
        runRead("rd 0x10 again", 32'h10, 32'h0000_003F);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
